bayes_infer_seq: RTL and testbench
==================================

Name: bayes_infer_seq

Overview:
Upstream sequencer for the Bayesian_log2 likelihood array, with output capture. It accepts one inference request (an observation vector plus an iteration count) through a valid/ready handshake. It drives instructions_in and adr_full_row_in/adr_full_col_in of the array, then issues read_out and deserialises the per-row serial DATA_out bits into M-bit posterior words. Results are returned to the host on a second valid/ready handshake.

Parameters:
Narray, 2, log2 of array side; F = 2**Narray features/rows
Nword, 3, per-cell storage address width; M = 2**Nword bits per result word
N, Narray+Nword, full address width
READ_LAT, 2, cycles from driving instruction 01 to first valid DATA_out bit (input reg + register_out stage)
ITER_W, 8, width of iteration count

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  high only in IDLE
req_obs  in  F*Nword  obs[k] = req_obs[k*Nword +: Nword], observed value index for feature k
req_iter  in  ITER_W  number of full feature sweeps
instr_out  out  2  to instructions_in (11 prog, 10 read_mem, 01 read_out, 00 inference)
adr_row_out  out  N  to adr_full_row_in
adr_col_out  out  N  to adr_full_col_in
cbl_out, cblen_out, csl_out, cwl_out  out  1 each  to CBL0/CBLEN0/CSL0/CWL0; constant 0 in this block
data_in  in  F  from DATA_out, bit i = row i
res_valid  out  1  result held
res_ready  in  1  host accepts result
res_data  out  F*M  word i = res_data[i*M +: M], LSB = first captured bit
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, instr_out=2'b10 (read_mem, non-destructive idle code), adr_row_out=0, adr_col_out=0, res_valid=0, res_data=0, busy=0, all counters 0. Reset mid-operation abandons the request; no partial result is produced.
- All outputs are registered; no combinational path from inputs to outputs except req_ready (decoded from state).
- IDLE: req_valid&req_ready latches obs and req_iter. Next state is INFER if req_iter≠0, else DRAIN.
- INFER: each cycle drive instr_out=00, adr_col_out=0, adr_row_out={feat_cnt[Narray-1:0], obs[feat_cnt]}. feat_cnt runs 0..F-1 and wraps. On wrap iter_cnt increments. When iter_cnt reaches req_iter-1 and feat_cnt=F-1, go to DRAIN. Total INFER cycles = F*req_iter exactly.
- DRAIN: instr_out=10, hold for READ_LAT cycles so in-flight inference completes, then go to READ.
- READ: instr_out=01 for M cycles (bit_cnt 0..M-1). A capture pointer lags by READ_LAT. Sample data_in[i] into word i bit cap_cnt for M consecutive cycles beginning READ_LAT cycles after the first 01 cycle. instr_out returns to 10 after M cycles. State stays READ until cap_cnt=M-1 is captured, then goes to DONE. READ length = M+READ_LAT cycles.
- DONE: res_valid=1, res_data stable. On res_valid&res_ready, clear res_valid and go to IDLE. res_ready low holds DONE indefinitely. req_valid is ignored while busy.
- req_iter max (2**ITER_W-1) must not overflow iter_cnt; iter_cnt is ITER_W wide, compared before increment.
- res_data is cleared at entry to READ so stale bits never leak.

Decomposition:
- bayes_pkg: state enum {IDLE, INFER, DRAIN, READ, DONE}; instruction code constants INSTR_PROG=2'b11, INSTR_RDMEM=2'b10, INSTR_RDOUT=2'b01, INSTR_INFER=2'b00.
- Sub-module bayes_out_deser: F parallel M-bit shift-in registers with clear, enable and a bit pointer. It is instantiated once; the FSM and counters stay in the top.

Test Plan:
- Reset hold 3 cycles with random inputs -> instr_out=10, res_valid=0, req_ready=1, busy=0, adr outputs 0.
- Request obs={3,0,7,5}, req_iter=1 -> exactly 4 INFER cycles with adr_row_out = 0x03, 0x08, 0x17, 0x1D; then 2 DRAIN cycles; then 8 cycles of 01.
- Model drives data_in rows with serial 0xA5, 0x3C, 0xFF, 0x01 (LSB first), READ_LAT after first 01 -> res_data words equal those values; res_valid asserted.
- req_iter=0 -> no 00 cycles; DRAIN then READ directly; result still produced.
- req_iter=3 with res_ready low 10 cycles after res_valid -> exactly 12 INFER cycles; res_valid and res_data held stable; a second req_valid during this time is ignored (req_ready=0); IDLE only after the handshake.
- rst_n pulsed low during the 6th INFER cycle -> next cycle instr_out=10, state IDLE, no res_valid; a following request completes normally.

Source files
------------

// File: rtl/bayes_pkg.sv
// Shared types and instruction codes for the Bayesian_log2 array sequencer.
package bayes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INFER = 3'd1,
    DRAIN = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] INSTR_PROG  = 2'b11;
  localparam logic [1:0] INSTR_RDMEM = 2'b10;
  localparam logic [1:0] INSTR_RDOUT = 2'b01;
  localparam logic [1:0] INSTR_INFER = 2'b00;

endpackage

// File: rtl/bayes_out_deser.sv
// F parallel M-bit shift-in registers: row i's serial bit lands in word i at bit ptr.
module bayes_out_deser
  import bayes_pkg::*;
#(
  parameter int F     = 4,
  parameter int M     = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [PTR_W-1:0]   ptr,
  input  logic [F-1:0]       data_in,
  output logic [F*M-1:0]     words
);

  logic [F*M-1:0] words_q;
  logic [F*M-1:0] words_d;

  always_comb begin
    words_d = words_q;
    if (clr) begin
      words_d = '0;
    end else if (en) begin
      for (int i = 0; i < F; i++) begin
        words_d[i*M + int'(ptr)] = data_in[i];
      end
    end
  end

  // NOTE: the result words are a handful of flops, not a RAM, so they take the
  // reset too; this guarantees res_data reads zero after any reset.
  always_ff @(posedge clk) begin
    if (!rst_n) words_q <= '0;
    else        words_q <= words_d;
  end

  assign words = words_q;

endmodule

// File: rtl/bayes_infer_seq.sv
// Sequencer for the Bayesian_log2 array: runs inference sweeps, then reads out
// and deserialises the per-row posterior bits and returns them to the host.
module bayes_infer_seq
  import bayes_pkg::*;
#(
  parameter int NARRAY   = 2,
  parameter int NWORD    = 3,
  parameter int READ_LAT = 2,
  parameter int ITER_W   = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [(1<<NARRAY)*NWORD-1:0]        req_obs,
  input  logic [ITER_W-1:0]                   req_iter,
  output logic [1:0]                          instr_out,
  output logic [NARRAY+NWORD-1:0]             adr_row_out,
  output logic [NARRAY+NWORD-1:0]             adr_col_out,
  output logic                                cbl_out,
  output logic                                cblen_out,
  output logic                                csl_out,
  output logic                                cwl_out,
  input  logic [(1<<NARRAY)-1:0]              data_in,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [(1<<NARRAY)*(1<<NWORD)-1:0]   res_data,
  output logic                                busy
);

  localparam int F     = 1 << NARRAY;
  localparam int M     = 1 << NWORD;
  localparam int N     = NARRAY + NWORD;
  localparam int CNT_W = $clog2(M + READ_LAT + 1);

  state_e              state_q, state_d;
  logic [F*NWORD-1:0]  obs_q, obs_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [NARRAY-1:0]   feat_q, feat_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [1:0]          instr_q, instr_d;
  logic [N-1:0]        adr_row_q, adr_row_d;
  logic                res_valid_q, res_valid_d;
  logic                busy_q, busy_d;

  logic                cap_clr;
  logic                cap_en;
  logic [NWORD-1:0]    cap_ptr;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    obs_d      = obs_q;
    iter_d     = iter_q;
    iter_cnt_d = iter_cnt_q;
    feat_d     = feat_q;
    cyc_d      = cyc_q;

    unique case (state_q)
      IDLE: begin
        feat_d     = '0;
        iter_cnt_d = '0;
        cyc_d      = '0;
        if (req_valid) begin
          obs_d   = req_obs;
          iter_d  = req_iter;
          state_d = (req_iter != '0) ? INFER : DRAIN;
        end
      end
      INFER: begin
        feat_d = feat_q + NARRAY'(1);
        if (feat_q == NARRAY'(F - 1)) begin
          // Compared before increment so iter_cnt never exceeds req_iter-1.
          if (iter_cnt_q == iter_q - ITER_W'(1)) state_d = DRAIN;
          else                                   iter_cnt_d = iter_cnt_q + ITER_W'(1);
        end
      end
      DRAIN: begin
        cyc_d = cyc_q + CNT_W'(1);
        if (cyc_q == CNT_W'(READ_LAT - 1)) begin
          state_d = READ;
          cyc_d   = '0;
        end
      end
      READ: begin
        cyc_d = cyc_q + CNT_W'(1);
        if (cyc_q == CNT_W'(M + READ_LAT - 1)) begin
          state_d = DONE;
          cyc_d   = '0;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    instr_d   = INSTR_RDMEM;
    adr_row_d = '0;
    if (state_d == INFER) begin
      instr_d   = INSTR_INFER;
      adr_row_d = {feat_d, obs_d[feat_d*NWORD +: NWORD]};
    end else if (state_d == READ && cyc_d < CNT_W'(M)) begin
      instr_d = INSTR_RDOUT;
    end
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      obs_q       <= '0;
      iter_q      <= '0;
      iter_cnt_q  <= '0;
      feat_q      <= '0;
      cyc_q       <= '0;
      instr_q     <= INSTR_RDMEM;
      adr_row_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      obs_q       <= obs_d;
      iter_q      <= iter_d;
      iter_cnt_q  <= iter_cnt_d;
      feat_q      <= feat_d;
      cyc_q       <= cyc_d;
      instr_q     <= instr_d;
      adr_row_q   <= adr_row_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Capture pointer trails the read-out instruction by the array's read latency.
  assign cap_clr = (state_q == DRAIN) && (state_d == READ);
  assign cap_en  = (state_q == READ) && (cyc_q >= CNT_W'(READ_LAT));
  assign cap_ptr = NWORD'(cyc_q - CNT_W'(READ_LAT));

  bayes_out_deser #(
    .F     (F),
    .M     (M),
    .PTR_W (NWORD)
  ) u_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cap_clr),
    .en      (cap_en),
    .ptr     (cap_ptr),
    .data_in (data_in),
    .words   (res_data)
  );

  assign req_ready   = (state_q == IDLE);
  assign instr_out   = instr_q;
  assign adr_row_out = adr_row_q;
  assign adr_col_out = '0;
  assign cbl_out     = 1'b0;
  assign cblen_out   = 1'b0;
  assign csl_out     = 1'b0;
  assign cwl_out     = 1'b0;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bayes_infer_seq.sv
// Directed bench for bayes_infer_seq: a bit-serial array model feeds DATA_out
// and expected words, instruction traces and row addresses are hand-computed.
module tb_bayes_infer_seq;

  localparam int F        = 4;
  localparam int M        = 8;
  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_obs;
  logic [7:0]  req_iter;
  logic [1:0]  instr_out;
  logic [4:0]  adr_row_out;
  logic [4:0]  adr_col_out;
  logic        cbl_out, cblen_out, csl_out, cwl_out;
  logic [3:0]  data_in;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [1:0] trace[$];
  logic [4:0] adr_log[$];

  bayes_infer_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_obs     (req_obs),
    .req_iter    (req_iter),
    .instr_out   (instr_out),
    .adr_row_out (adr_row_out),
    .adr_col_out (adr_col_out),
    .cbl_out     (cbl_out),
    .cblen_out   (cblen_out),
    .csl_out     (csl_out),
    .cwl_out     (cwl_out),
    .data_in     (data_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Per-cycle record of what the sequencer drives while it is busy.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      trace.push_back(instr_out);
      if (instr_out === 2'b00) adr_log.push_back(adr_row_out);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request: handshake, wait for read-out, play the serial rows,
  // optionally stall the result, then check the recorded instruction trace.
  task automatic run_request(input string tag, input logic [11:0] obs, input logic [7:0] iter,
                             input logic [31:0] words, input int stall);
    int start;
    int n00, n01, first01;
    logic [31:0] held;
    start = trace.size();
    req_obs   = obs;
    req_iter  = iter;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'(1));
    check({tag, "_ready_low"}, 64'(req_ready), 64'(0));

    for (int c = 0; c < 2000 && instr_out !== 2'b01; c++) tick();
    check({tag, "_rdout_seen"}, 64'(instr_out), 64'(2'b01));

    repeat (READ_LAT) tick();
    for (int k = 0; k < M; k++) begin
      for (int i = 0; i < F; i++) data_in[i] = words[i*M + k];
      tick();
    end
    data_in = 4'($urandom);

    check({tag, "_res_valid"}, 64'(res_valid), 64'(1));
    check({tag, "_res_data"}, 64'(res_data), 64'(words));
    check({tag, "_done_instr"}, 64'(instr_out), 64'(2'b10));

    held = res_data;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_obs   = 12'hFFF;
      req_iter  = 8'd5;
      tick();
      if (s == 0 || s == stall - 1) begin
        check({tag, "_stall_valid"}, 64'(res_valid), 64'(1));
        check({tag, "_stall_data"}, 64'(res_data), 64'(held));
        check({tag, "_stall_ready"}, 64'(req_ready), 64'(0));
      end
    end
    req_valid = 1'b0;

    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_release_valid"}, 64'(res_valid), 64'(0));
    check({tag, "_release_ready"}, 64'(req_ready), 64'(1));
    check({tag, "_release_busy"}, 64'(busy), 64'(0));

    n00 = 0;
    n01 = 0;
    first01 = -1;
    for (int j = start; j < trace.size(); j++) begin
      if (trace[j] == 2'b00) n00++;
      if (trace[j] == 2'b01) begin
        n01++;
        if (first01 < 0) first01 = j - start;
      end
    end
    check({tag, "_infer_cycles"}, 64'(n00), 64'(F * int'(iter)));
    check({tag, "_rdout_cycles"}, 64'(n01), 64'(M));
    check({tag, "_first_rdout"}, 64'(first01), 64'(F * int'(iter) + READ_LAT));
  endtask

  initial begin
    int adr_start;

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'($urandom);
      req_obs   = 12'($urandom);
      req_iter  = 8'($urandom);
      res_ready = 1'($urandom);
      data_in   = 4'($urandom);
      tick();
    end
    check("rst_instr", 64'(instr_out), 64'(2'b10));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_adr", 64'({adr_row_out, adr_col_out}), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    req_valid = 1'b0;
    res_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_ctrl_lines", 64'({cbl_out, cblen_out, csl_out, cwl_out}), 64'(0));

    // obs = {3,0,7,5} for features 0..3, one sweep; rows 0xA5,0x3C,0xFF,0x01.
    adr_start = adr_log.size();
    run_request("iter1", {3'd5, 3'd7, 3'd0, 3'd3}, 8'd1, 32'h01FF3CA5, 0);
    check("iter1_adr_count", 64'(adr_log.size() - adr_start), 64'(4));
    if (adr_log.size() - adr_start >= 4) begin
      check("iter1_adr0", 64'(adr_log[adr_start + 0]), 64'(5'h03));
      check("iter1_adr1", 64'(adr_log[adr_start + 1]), 64'(5'h08));
      check("iter1_adr2", 64'(adr_log[adr_start + 2]), 64'(5'h17));
      check("iter1_adr3", 64'(adr_log[adr_start + 3]), 64'(5'h1D));
    end

    // Zero sweeps: straight to drain and read-out.
    run_request("iter0", 12'h5A3, 8'd0, 32'h78563412, 0);

    // Three sweeps, result stalled 10 cycles with a competing request offered.
    adr_start = adr_log.size();
    run_request("iter3", {3'd1, 3'd6, 3'd2, 3'd4}, 8'd3, 32'h8000C35A, 10);
    check("iter3_adr_count", 64'(adr_log.size() - adr_start), 64'(12));
    if (adr_log.size() - adr_start >= 12) begin
      check("iter3_adr4", 64'(adr_log[adr_start + 4]), 64'(5'h04));
      check("iter3_adr11", 64'(adr_log[adr_start + 11]), 64'(5'h19));
    end

    // Reset pulse during the 6th INFER cycle abandons the request.
    req_obs   = 12'h123;
    req_iter  = 8'd3;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check("midrst_in_infer", 64'(instr_out), 64'(2'b00));
    rst_n = 1'b0;
    tick();
    check("midrst_instr", 64'(instr_out), 64'(2'b10));
    check("midrst_ready", 64'(req_ready), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_res_valid", 64'(res_valid), 64'(0));
    check("midrst_res_data", 64'(res_data), 64'(0));
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst_no_result", 64'(res_valid), 64'(0));

    // Normal request after the reset: obs = {1,2,3,4}, two sweeps.
    run_request("after_rst", {3'd4, 3'd3, 3'd2, 3'd1}, 8'd2, 32'h55AAF00F, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
